fsmd_operand_sequencer: RTL and testbench
=========================================

FSMD_OPERAND_SEQUENCER -- requirements
Module: fsmd_operand_sequencer

Interface
REQ-001 Parameter W, default 4, operand and result width in bits.
REQ-002 Parameter TIMEOUT, default 15, maximum WAIT cycles before abort; legal range 1..255.
REQ-003 clock  input  1  single system clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand stream valid.
REQ-006 in_data  input  W  operand stream data.
REQ-007 in_ready  output  1  sequencer accepts an operand this cycle.
REQ-008 a, b, c, d, e  output  W each  operand bus to the compute engine.
REQ-009 start  output  1  one-cycle engine start pulse.
REQ-010 done  input  1  engine completion strobe.
REQ-011 r1, r2, r3  input  W each  engine results, valid while done=1.
REQ-012 res_valid  output  1  result word available.
REQ-013 res_ready  input  1  downstream accepts the result.
REQ-014 res_data  output  3W  captured result, ordered {r1,r2,r3} with r1 in the MSBs.
REQ-015 err  output  1  timeout flag.
REQ-016 ps  output  3  present-state code.

Function
REQ-017 The FSM SHALL have these five states and codes: LOAD=0, START=1, WAIT=2, OUT=3, ERR=4.
REQ-018 LOAD: in_ready=1; an operand is accepted when in_valid&in_ready.
  - 1st accepted operand goes to a, 2nd to b, 3rd to c, 4th to d, 5th to e.
  - A 3-bit operand counter advances on each accept.
  - The FSM goes to START on the edge that accepts the 5th operand.
  - Cycles with in_valid=0 leave the counter and state unchanged.
REQ-019 in_ready SHALL be 0 in every state other than LOAD.
REQ-020 START: start=1 for exactly one cycle, wait timer cleared to 0, then WAIT.
REQ-021 a..e SHALL hold their values unchanged from the 5th accept until the FSM next leaves OUT or ERR.
REQ-022 WAIT:
  - done=1 captures {r1,r2,r3} into res_data and goes to OUT.
  - Otherwise the timer increments by 1.
  - When the timer reaches TIMEOUT with done=0, the FSM goes to ERR.
REQ-023 done SHALL be ignored in every state except WAIT.
REQ-024 When done=1 arrives on the same cycle the timer reaches TIMEOUT, done SHALL win and the FSM goes to OUT.
REQ-025 OUT: res_valid=1 and res_data stable.
  - res_ready=1 returns the FSM to LOAD with the counter at 0.
  - res_ready=0 keeps the FSM in OUT indefinitely.
REQ-026 ERR: lasts exactly one cycle with res_valid=0, sets err=1, then returns to LOAD with the counter at 0.
REQ-027 err SHALL be sticky until the next START cycle, which clears it.
REQ-028 res_valid SHALL be 1 only in OUT, and start SHALL be 1 only in START.
REQ-029 Latency: start SHALL assert the cycle after the 5th accept, and res_valid the cycle after done is sampled in WAIT.
REQ-030 ps SHALL reflect the registered present state.

Reset
REQ-031 reset=0 SHALL immediately force, with no clock required:
  - state LOAD and counter 0;
  - a..e=0, res_data=0, timer=0;
  - start=0, res_valid=0, err=0.
REQ-032 Assertion of reset in any state, including mid-WAIT or OUT, SHALL discard the in-progress operation, and no result SHALL be emitted afterwards.
REQ-033 After reset is released, the first rising edge SHALL operate normally from LOAD, and in_ready SHALL be 1 during reset release.

Verification
REQ-034 Operand load: in_data 1,2,3,4,5 on consecutive valid cycles -> a=1, b=2, c=3, d=4, e=5; start=1 for one cycle the cycle after the 5th accept; ps goes 0->1->2.
REQ-035 Result capture: done=1 on the 3rd WAIT cycle with r1=7, r2=8, r3=9 -> res_data=0x789 and res_valid=1 the next cycle; with res_ready held 0 for 4 cycles, res_valid stays 1 and res_data stays 0x789; res_ready=1 -> ps returns to 0.
REQ-036 Stream gaps: in_valid toggling 1,0,0,1,1,0,1,1 with data 3,x,x,6,9,x,12,15 -> a..e=3,6,9,12,15; start asserts only after the 5th accept.
REQ-037 Timeout: TIMEOUT=15 and done held 0 -> ERR after 15 WAIT cycles, err=1, res_valid never 1; next start clears err; done=1 on the 15th WAIT cycle -> OUT instead of ERR.
REQ-038 Reset mid-operation: reset=0 in WAIT -> all outputs 0 and ps=0 with no clock edge; a later done pulse does not set res_valid.

Source files
------------

// File: rtl/fsmd_operand_sequencer.sv
// Operand sequencer: gathers five operands from a valid/ready stream, starts
// a compute engine, waits (with timeout) for its done strobe, and holds the
// captured three-word result until downstream accepts it.
module fsmd_operand_sequencer #(
    parameter int W       = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    output logic [W-1:0]     a,
    output logic [W-1:0]     b,
    output logic [W-1:0]     c,
    output logic [W-1:0]     d,
    output logic [W-1:0]     e,
    output logic             start,
    input  logic             done,
    input  logic [W-1:0]     r1,
    input  logic [W-1:0]     r2,
    input  logic [W-1:0]     r3,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3*W-1:0]   res_data,
    output logic             err,
    output logic [2:0]       ps
);

    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        OUT   = 3'd3,
        ERR   = 3'd4
    } state_t;

    // Timer value during the last WAIT cycle allowed before aborting.
    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

    state_t      state, nxt;
    logic [2:0]  cnt;
    logic [7:0]  timer;
    logic        accept;

    // Present-state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= LOAD;
        else        state <= nxt;
    end

    // Next-state decode and Moore-style handshake outputs.
    always_comb begin
        nxt       = state;
        in_ready  = 1'b0;
        start     = 1'b0;
        res_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid && cnt == 3'd4) nxt = START;
            end
            START: begin
                start = 1'b1;
                nxt   = WAIT;
            end
            WAIT: begin
                // done has priority over an expiring timer
                if (done)                nxt = OUT;
                else if (timer == TLAST) nxt = ERR;
            end
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) nxt = LOAD;
            end
            ERR:     nxt = LOAD;
            default: nxt = LOAD;
        endcase
    end

    // Operand counter; it wraps on the fifth accept and is forced to 0
    // whenever the sequencer is outside LOAD.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                     cnt <= '0;
        else if (accept)                cnt <= (cnt == 3'd4) ? 3'd0 : cnt + 3'd1;
        else if (state != LOAD)         cnt <= '0;
    end

    // Operand registers; they only load in LOAD so they stay frozen otherwise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a <= '0; b <= '0; c <= '0; d <= '0; e <= '0;
        end else if (accept) begin
            case (cnt)
                3'd0:    a <= in_data;
                3'd1:    b <= in_data;
                3'd2:    c <= in_data;
                3'd3:    d <= in_data;
                3'd4:    e <= in_data;
                default: ;
            endcase
        end
    end

    // WAIT timer: cleared in START, counts WAIT cycles without done.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                       timer <= '0;
        else if (state == START)          timer <= '0;
        else if (state == WAIT && !done)  timer <= timer + 8'd1;
    end

    // Result capture on the done strobe seen in WAIT.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                      res_data <= '0;
        else if (state == WAIT && done)  res_data <= {r1, r2, r3};
    end

    // Sticky timeout flag: set when entering ERR, cleared by the next START.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                             err <= 1'b0;
        else if (state == WAIT && nxt == ERR)   err <= 1'b1;
        else if (state == START)                err <= 1'b0;
    end

    assign ps = state;

endmodule

// File: tb/tb_fsmd_operand_sequencer.sv
// Bench for fsmd_operand_sequencer: table-driven operand loads plus
// hand-written result, timeout and reset sequences, with a result scoreboard.
module tb_fsmd_operand_sequencer;

    localparam int W = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic           in_ready;
    logic [W-1:0]   a, b, c, d, e;
    logic           start;
    logic           done;
    logic [W-1:0]   r1, r2, r3;
    logic           res_valid;
    logic           res_ready;
    logic [3*W-1:0] res_data;
    logic           err;
    logic [2:0]     ps;

    int passed = 0;
    int total  = 0;

    logic [3*W-1:0] sb_q[$];

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic [2:0]   ps;
        logic         st;
    } vec_t;

    vec_t load_tab[5];
    vec_t gap_tab[8];

    fsmd_operand_sequencer #(.W(W), .TIMEOUT(15)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d), .e(e),
        .start(start), .done(done), .r1(r1), .r2(r2), .r3(r3),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .err(err), .ps(ps)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        in_valid = v.v;
        in_data  = v.d;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        chk({tag, "_ps"}, 32'(ps), 32'(v.ps));
        chk({tag, "_start"}, 32'(start), 32'(v.st));
        in_valid = 1'b0;
    endtask

    task automatic check_ops(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb,
                             input logic [W-1:0] ec, input logic [W-1:0] ed, input logic [W-1:0] ee);
        chk({tag, "_a"}, 32'(a), 32'(ea));
        chk({tag, "_b"}, 32'(b), 32'(eb));
        chk({tag, "_c"}, 32'(c), 32'(ec));
        chk({tag, "_d"}, 32'(d), 32'(ed));
        chk({tag, "_e"}, 32'(e), 32'(ee));
    endtask

    // Back-to-back load of five operands; ends one cycle into START.
    task automatic load5(input string tag, input logic [W-1:0] o0, input logic [W-1:0] o1,
                         input logic [W-1:0] o2, input logic [W-1:0] o3, input logic [W-1:0] o4);
        logic [W-1:0] ops[5];
        ops = '{o0, o1, o2, o3, o4};
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = ops[i];
            tick();
        end
        in_valid = 1'b0;
        chk({tag, "_ps_start"}, 32'(ps), 32'd1);
        chk({tag, "_start"}, 32'(start), 32'd1);
        check_ops(tag, o0, o1, o2, o3, o4);
    endtask

    // Compare the DUT result against the oldest scoreboard entry.
    task automatic pop_result(input string tag);
        logic [3*W-1:0] exp;
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd1);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            exp = sb_q.pop_front();
            chk({tag, "_res_data"}, 32'(res_data), 32'(exp));
        end
    endtask

    initial begin
        logic [W-1:0] ro[5];
        int           rv_seen;

        load_tab[0] = '{1'b1, 4'd1, 3'd0, 1'b0};
        load_tab[1] = '{1'b1, 4'd2, 3'd0, 1'b0};
        load_tab[2] = '{1'b1, 4'd3, 3'd0, 1'b0};
        load_tab[3] = '{1'b1, 4'd4, 3'd0, 1'b0};
        load_tab[4] = '{1'b1, 4'd5, 3'd1, 1'b1};

        gap_tab[0] = '{1'b1, 4'd3,  3'd0, 1'b0};
        gap_tab[1] = '{1'b0, 4'd0,  3'd0, 1'b0};
        gap_tab[2] = '{1'b0, 4'd0,  3'd0, 1'b0};
        gap_tab[3] = '{1'b1, 4'd6,  3'd0, 1'b0};
        gap_tab[4] = '{1'b1, 4'd9,  3'd0, 1'b0};
        gap_tab[5] = '{1'b0, 4'd7,  3'd0, 1'b0};
        gap_tab[6] = '{1'b1, 4'd12, 3'd0, 1'b0};
        gap_tab[7] = '{1'b1, 4'd15, 3'd1, 1'b1};

        reset = 1'b0; in_valid = 1'b0; in_data = '0; done = 1'b0;
        r1 = '0; r2 = '0; r3 = '0; res_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_ps", 32'(ps), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        check_ops("rst", 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        reset = 1'b1;

        // Operand load 1..5
        for (int i = 0; i < 5; i++) apply_vec(load_tab[i], "load");
        check_ops("load", 4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
        tick();
        chk("load_ps_wait", 32'(ps), 32'd2);
        chk("load_start_once", 32'(start), 32'd0);
        chk("wait_in_ready", 32'(in_ready), 32'd0);

        // Result capture on the 3rd WAIT cycle
        tick();
        tick();
        chk("cap_ps_wait3", 32'(ps), 32'd2);
        done = 1'b1; r1 = 4'd7; r2 = 4'd8; r3 = 4'd9;
        sb_q.push_back({4'd7, 4'd8, 4'd9});
        tick();
        done = 1'b0; r1 = 4'd1; r2 = 4'd1; r3 = 4'd1;
        chk("cap_ps_out", 32'(ps), 32'd3);
        pop_result("cap");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_res_valid", 32'(res_valid), 32'd1);
            chk("hold_res_data", 32'(res_data), 32'h789);
        end
        check_ops("hold", 4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("release_ps", 32'(ps), 32'd0);
        chk("release_res_valid", 32'(res_valid), 32'd0);

        // done is ignored outside WAIT
        done = 1'b1; r1 = 4'hA; r2 = 4'hB; r3 = 4'hC;
        tick();
        done = 1'b0;
        chk("ign_done_ps", 32'(ps), 32'd0);
        chk("ign_done_res_data", 32'(res_data), 32'h789);

        // Stream gaps
        for (int i = 0; i < 8; i++) apply_vec(gap_tab[i], "gap");
        check_ops("gap", 4'd3, 4'd6, 4'd9, 4'd12, 4'd15);
        tick();
        chk("gap_ps_wait", 32'(ps), 32'd2);

        // Timeout: 15 WAIT cycles without done
        rv_seen = 0;
        for (int i = 1; i < 15; i++) begin
            tick();
            if (ps != 3'd2) chk("to_stay_wait", 32'(ps), 32'd2);
            if (res_valid) rv_seen++;
        end
        chk("to_ps_before", 32'(ps), 32'd2);
        tick();
        chk("to_ps_err", 32'(ps), 32'd4);
        chk("to_err", 32'(err), 32'd1);
        chk("to_res_valid_err", 32'(res_valid), 32'd0);
        tick();
        chk("to_ps_load", 32'(ps), 32'd0);
        chk("to_err_sticky", 32'(err), 32'd1);
        chk("to_no_res_valid", 32'(rv_seen), 32'd0);

        // Next START clears err; done on the 15th WAIT cycle wins
        for (int i = 0; i < 5; i++) ro[i] = W'($urandom_range(0, 15));
        load5("rnd", ro[0], ro[1], ro[2], ro[3], ro[4]);
        tick();
        chk("rnd_ps_wait", 32'(ps), 32'd2);
        chk("rnd_err_cleared", 32'(err), 32'd0);
        for (int i = 1; i < 15; i++) tick();
        chk("edge_ps_wait15", 32'(ps), 32'd2);
        r1 = W'($urandom_range(0, 15)); r2 = W'($urandom_range(0, 15)); r3 = W'($urandom_range(0, 15));
        done = 1'b1;
        sb_q.push_back({r1, r2, r3});
        tick();
        done = 1'b0;
        chk("edge_ps_out", 32'(ps), 32'd3);
        chk("edge_err", 32'(err), 32'd0);
        pop_result("edge");
        check_ops("edge", ro[0], ro[1], ro[2], ro[3], ro[4]);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("edge_ps_load", 32'(ps), 32'd0);

        // Asynchronous reset in the middle of WAIT
        load5("mid", 4'd9, 4'd8, 4'd7, 4'd6, 4'd5);
        tick();
        tick();
        chk("mid_ps_wait", 32'(ps), 32'd2);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_ps", 32'(ps), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_start", 32'(start), 32'd0);
        chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_res_data", 32'(res_data), 32'd0);
        check_ops("mid_rst", 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        #2 reset = 1'b1;
        done = 1'b1; r1 = 4'h3; r2 = 4'h4; r3 = 4'h5;
        tick();
        done = 1'b0;
        tick();
        chk("mid_late_done_res_valid", 32'(res_valid), 32'd0);
        chk("mid_late_done_ps", 32'(ps), 32'd0);
        chk("mid_late_done_res_data", 32'(res_data), 32'd0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
